// File: rtl/rr_request_encoder_pkg.sv
// Shared definitions for rr_request_encoder: FSM encoding and index-width helper.
// Build option RR_ENC_FIXED_PRI_EN selects fixed priority instead of round-robin.
package rr_request_encoder_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  // Smallest width able to encode indices 0..n-1 (at least 1 bit).
  function automatic int idx_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w++;
    return w;
  endfunction

endpackage

// File: rtl/rr_request_encoder_pick.sv
// Combinational pick: first set request at or above ptr, wrapping N-1 -> 0.
// Rotate so ptr lands on bit 0, take the lowest set bit, then rotate the index back.
module rr_pick
  import rr_request_encoder_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic [N-1:0]     onehot,
  output logic             any
);

  logic [N-1:0]     rot;
  logic [IDX_W-1:0] off;
  logic [IDX_W:0]   sum;

  assign rot = N'({req, req} >> ptr);
  assign any = |req;

  always_comb begin
    off = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rot[j]) off = IDX_W'(j);
    end
  end

  // ptr < N and off < N, so one conditional subtract is a full mod N.
  always_comb begin
    sum = {1'b0, off} + {1'b0, ptr};
    if (sum >= (IDX_W + 1)'(N)) sum = sum - (IDX_W + 1)'(N);
  end

  assign idx    = sum[IDX_W-1:0];
  assign onehot = any ? (N'(1) << idx) : '0;

endmodule

// File: rtl/rr_request_encoder.sv
// Round-robin request encoder: registered binary index + one-hot grant over valid/ready.
// Define RR_ENC_FIXED_PRI_EN for fixed lowest-index priority instead of round-robin.
module rr_request_encoder
  import rr_request_encoder_pkg::*;
#(
  parameter int N     = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N-1:0]     req,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [IDX_W-1:0] out_idx,
  output logic [N-1:0]     out_onehot,
  output logic             busy_any
);

  if (N < 2 || N > 16 || IDX_W < idx_width(N)) begin : g_bad_cfg
    $error("rr_request_encoder: unsupported N/IDX_W combination");
  end

  state_t           state;
  logic [IDX_W-1:0] pick_ptr;
  logic [IDX_W-1:0] pick_idx;
  logic [N-1:0]     pick_onehot;
  logic             pick_any;

`ifdef RR_ENC_FIXED_PRI_EN
  assign pick_ptr = '0;
`else
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] nxt_ptr;
  logic             accept;

  assign accept   = (state == ST_HOLD) && out_ready;
  assign nxt_ptr  = (out_idx == IDX_W'(N - 1)) ? '0 : out_idx + IDX_W'(1);
  // On accept the follow-on pick must already see the advanced pointer.
  assign pick_ptr = accept ? nxt_ptr : ptr;

  always_ff @(posedge clk) begin
    if (reset)       ptr <= '0;
    else if (accept) ptr <= nxt_ptr;
  end
`endif

  rr_pick #(.N(N), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (pick_ptr),
    .idx    (pick_idx),
    .onehot (pick_onehot),
    .any    (pick_any)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      out_valid  <= 1'b0;
      out_idx    <= '0;
      out_onehot <= '0;
      busy_any   <= 1'b0;
    end else begin
      busy_any <= |req;
      case (state)
        ST_IDLE: begin
          if (pick_any) begin
            state      <= ST_HOLD;
            out_valid  <= 1'b1;
            out_idx    <= pick_idx;
            out_onehot <= pick_onehot;
          end
        end
        ST_HOLD: begin
          if (out_ready) begin
            if (pick_any) begin
              out_idx    <= pick_idx;
              out_onehot <= pick_onehot;
            end else begin
              // out_idx deliberately keeps its last value when going idle.
              state      <= ST_IDLE;
              out_valid  <= 1'b0;
              out_onehot <= '0;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_request_encoder.sv
// Randomized + directed bench for rr_request_encoder (N=8 and N=6 instances) against a behavioural model.
module tb_rr_request_encoder;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       out_ready = 1'b0;
  logic [7:0] req8 = '0;
  logic [5:0] req6 = '0;

  logic       vld8, busy8, vld6, busy6;
  logic [2:0] idx8, idx6;
  logic [7:0] oh8;
  logic [5:0] oh6;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  rr_request_encoder #(.N(8), .IDX_W(3)) dut8 (
    .clk(clk), .reset(reset), .req(req8), .out_ready(out_ready),
    .out_valid(vld8), .out_idx(idx8), .out_onehot(oh8), .busy_any(busy8)
  );

  rr_request_encoder #(.N(6), .IDX_W(3)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .out_ready(out_ready),
    .out_valid(vld6), .out_idx(idx6), .out_onehot(oh6), .busy_any(busy6)
  );

  // Model state per instance: [0] = N=8, [1] = N=6.
  int m_ptr[2];
  int m_idx[2];
  bit m_vld[2];
  bit m_busy[2];

  function automatic int pick(input logic [15:0] r, input int p, input int n);
    for (int k = 0; k < n; k++) begin
      int b;
      b = (p + k) % n;
      if (r[b]) return b;
    end
    return 0;
  endfunction

  task automatic model_step(input int u, input logic [15:0] r, input int n);
    if (reset) begin
      m_vld[u] = 0; m_idx[u] = 0; m_ptr[u] = 0; m_busy[u] = 0;
    end else begin
      m_busy[u] = (r != 0);
      if (!m_vld[u]) begin
        if (r != 0) begin
          m_vld[u] = 1;
          m_idx[u] = pick(r, m_ptr[u], n);
        end
      end else if (out_ready) begin
`ifndef RR_ENC_FIXED_PRI_EN
        m_ptr[u] = (m_idx[u] + 1) % n;
`endif
        if (r != 0) m_idx[u] = pick(r, m_ptr[u], n);
        else        m_vld[u] = 0;
      end
    end
  endtask

  always @(posedge clk) begin
    model_step(0, {8'h00, req8}, 8);
    model_step(1, {10'h000, req6}, 6);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("vld8",  32'(vld8),  32'(m_vld[0]));
    chk("idx8",  32'(idx8),  32'(m_idx[0]));
    chk("oh8",   32'(oh8),   m_vld[0] ? (32'd1 << m_idx[0]) : 32'd0);
    chk("busy8", 32'(busy8), 32'(m_busy[0]));
    chk("vld6",  32'(vld6),  32'(m_vld[1]));
    chk("idx6",  32'(idx6),  32'(m_idx[1]));
    chk("oh6",   32'(oh6),   m_vld[1] ? (32'd1 << m_idx[1]) : 32'd0);
    chk("busy6", 32'(busy6), 32'(m_busy[1]));
  end

  // Apply inputs at a falling edge, return at the next falling edge.
  task automatic drive(input logic [7:0] r8, input logic [5:0] r6, input logic rdy, input logic rs);
    req8 = r8; req6 = r6; out_ready = rdy; reset = rs;
    @(negedge clk);
  endtask

  int exp_rr[4];

  initial begin
    @(negedge clk);
    drive(8'h00, 6'h00, 1'b0, 1'b1);

    for (int i = 0; i < 5; i++) begin
      drive(8'h00, 6'h00, 1'b0, 1'b0);
      chk("idle_vld", 32'(vld8), 32'd0);
      chk("idle_oh", 32'(oh8), 32'd0);
      chk("idle_busy", 32'(busy8), 32'd0);
    end

`ifdef RR_ENC_FIXED_PRI_EN
    exp_rr = '{2, 2, 2, 2};
`else
    exp_rr = '{2, 4, 7, 2};
`endif
    for (int i = 0; i < 4; i++) begin
      drive(8'b1001_0100, 6'h00, 1'b1, 1'b0);
      chk("rr_seq_idx", 32'(idx8), 32'(exp_rr[i]));
    end
    drive(8'h00, 6'h00, 1'b1, 1'b0);
    chk("drain_vld", 32'(vld8), 32'd0);

    drive(8'h08, 6'h00, 1'b0, 1'b0);
    chk("bp_vld", 32'(vld8), 32'd1);
    chk("bp_idx", 32'(idx8), 32'd3);
    for (int i = 0; i < 4; i++) begin
      drive(8'h00, 6'h00, 1'b0, 1'b0);
      chk("hold_idx", 32'(idx8), 32'd3);
      chk("hold_oh", 32'(oh8), 32'h08);
    end
    drive(8'h00, 6'h00, 1'b1, 1'b0);
    chk("accept_vld", 32'(vld8), 32'd0);

    drive(8'h80, 6'b100000, 1'b0, 1'b0);
    chk("wrap_idx7", 32'(idx8), 32'd7);
    chk("wrap6_idx5", 32'(idx6), 32'd5);
    drive(8'h81, 6'b100001, 1'b1, 1'b0);
    chk("wrap_idx0", 32'(idx8), 32'd0);
    chk("wrap6_idx0", 32'(idx6), 32'd0);
    drive(8'h81, 6'b100001, 1'b1, 1'b0);
`ifdef RR_ENC_FIXED_PRI_EN
    chk("wrap_next", 32'(idx8), 32'd0);
    chk("wrap6_next", 32'(idx6), 32'd0);
`else
    chk("wrap_next", 32'(idx8), 32'd7);
    chk("wrap6_next", 32'(idx6), 32'd5);
`endif
    drive(8'h00, 6'h00, 1'b1, 1'b0);

    drive(8'h20, 6'h00, 1'b0, 1'b0);
    chk("pre_rst_idx", 32'(idx8), 32'd5);
    drive(8'h20, 6'h00, 1'b1, 1'b1);
    chk("rst_vld", 32'(vld8), 32'd0);
    chk("rst_idx", 32'(idx8), 32'd0);
    chk("rst_oh", 32'(oh8), 32'd0);
    drive(8'hFF, 6'h00, 1'b0, 1'b0);
    chk("post_rst_idx", 32'(idx8), 32'd0);

    for (int i = 0; i < 3000; i++) begin
      logic [7:0] r8;
      logic [5:0] r6;
      r8 = ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom);
      r6 = ($urandom_range(0, 3) == 0) ? 6'h00 : 6'($urandom);
      drive(r8, r6, $urandom_range(0, 9) < 7, $urandom_range(0, 199) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
